// File: rtl/mult_div_ctrl.sv
// Sequences multi-cycle mult/div cores and owns the architectural HI/LO registers (mthi/mtlo/mfhi/mflo).
// Latency: request T -> core start T+1 -> HI/LO written and done pulse in T+2+N (N = core cycles).
// Backpressure: busy stalls the control unit while a core runs; requests arriving while busy are dropped.
module mult_div_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_mult,
    input  logic        op_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_t;

    // Terminal counts: the core results are sampled on the edge that ends the cycle holding this count.
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      hi_nxt;
    logic [31:0]      lo_nxt;
    logic [31:0]      core_a_nxt;
    logic [31:0]      core_b_nxt;
    logic             done_nxt;
    logic             div_zero_nxt;
    logic             b_is_zero;

    assign b_is_zero = (b == 32'd0);

    // Status and start pulses decode from registered state only, so they never depend on inputs.
    assign busy       = (state != IDLE);
    assign mult_start = (state == MULT_RUN) && (cnt == '0);
    assign div_start  = (state == DIV_RUN)  && (cnt == '0);

    // State register and cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand latches, HI/LO and the one-cycle status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_a   <= 32'd0;
            core_b   <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            core_a   <= core_a_nxt;
            core_b   <= core_b_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            done     <= done_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    // Next-state, counter and register-update decode; flush beats both new requests and completion.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hi_nxt       = hi;
        lo_nxt       = lo;
        core_a_nxt   = core_a;
        core_b_nxt   = core_b;
        done_nxt     = 1'b0;
        div_zero_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!flush) begin
                    // mult wins over div; the losing request is simply dropped.
                    if (op_mult) begin
                        core_a_nxt = a;
                        core_b_nxt = b;
                        cnt_nxt    = '0;
                        state_nxt  = MULT_RUN;
                    end else if (op_div) begin
                        if (b_is_zero) begin
                            // No core start and no HI/LO write; only flag the fault.
                            div_zero_nxt = 1'b1;
                        end else begin
                            core_a_nxt = a;
                            core_b_nxt = b;
                            cnt_nxt    = '0;
                            state_nxt  = DIV_RUN;
                        end
                    end
                    // Moves to HI/LO proceed alongside any mult/div launch in the same cycle.
                    if (op_mthi) begin
                        hi_nxt = a;
                    end
                    if (op_mtlo) begin
                        lo_nxt = a;
                    end
                end
            end

            MULT_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == MULT_LAST) begin
                    hi_nxt    = mult_hi;
                    lo_nxt    = mult_lo;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DIV_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DIV_LAST) begin
                    // Quotient lands in LO, remainder in HI.
                    lo_nxt    = div_quot;
                    hi_nxt    = div_rem;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencing controller for the CPU's multi-cycle multiply and divide cores. Accepts mult/div requests from the main control unit, latches operands, starts the selected core, counts its fixed latency and writes the result into the architectural HI/LO registers. Also serves mfhi/mflo/mthi/mtlo and drives the pipeline stall while an operation is in flight. Sits between the control unit/register file and the mult and div datapath cores.

Parameters:
MULT_CYCLES, 32, cycles the mult core needs after its start cycle before hi/low outputs are valid
DIV_CYCLES, 32, same for the div core
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
op_mult  in  1  one-cycle request: signed multiply of a*b
op_div  in  1  one-cycle request: signed divide a/b
op_mthi  in  1  write a into HI
op_mtlo  in  1  write a into LO
flush  in  1  abort any in-flight operation (pipeline exception)
a  in  32  operand rs
b  in  32  operand rt
core_a  out  32  latched operand A to both cores
core_b  out  32  latched operand B to both cores
mult_start  out  1  start pulse to mult core
div_start  out  1  start pulse to div core
mult_hi  in  32  mult core upper product
mult_lo  in  32  mult core lower product
div_quot  in  32  div core quotient
div_rem  in  32  div core remainder
hi  out  32  architectural HI (mfhi source)
lo  out  32  architectural LO (mflo source)
busy  out  1  stall request to control unit
done  out  1  one-cycle pulse: HI/LO updated by mult/div
div_zero  out  1  one-cycle pulse: divide by zero detected

Behaviour:
- Reset (async, reset_n=0): state IDLE, cnt=0, hi=lo=core_a=core_b=0, all pulses and busy 0. Applies mid-operation; no partial HI/LO write.
- States: IDLE, MULT_RUN, DIV_RUN.
- IDLE: on op_mult, latch core_a<=a, core_b<=b, cnt<=0, go MULT_RUN. On op_div with b!=0, same, go DIV_RUN. On op_div with b==0: stay IDLE, div_zero=1 next cycle, HI/LO unchanged, no start.
- Priority when several ops assert together in IDLE: op_mult > op_div; the losing op is dropped. op_mthi/op_mtlo are independent of op_mult/op_div and write HI/LO at the same edge.
- RUN states: mult_start/div_start = 1 exactly while cnt==0 (first RUN cycle), else 0. cnt increments each cycle. On the edge where cnt==MULT_CYCLES (resp. DIV_CYCLES): mult writes hi<=mult_hi, lo<=mult_lo; div writes lo<=div_quot, hi<=div_rem. State returns to IDLE and done=1 for the following cycle.
- Latency: request in cycle T -> start in T+1 -> HI/LO valid and done=1 in cycle T+2+N (N=MULT_CYCLES/DIV_CYCLES).
- busy = (state != IDLE), registered-state decode; high from T+1 through T+1+N. Low in the done cycle, so a back-to-back op or mfhi may issue then.
- Requests (op_mult, op_div, op_mthi, op_mtlo) arriving while busy are ignored; the control unit guarantees none by stalling.
- flush: in RUN, next edge -> IDLE, cnt=0, no HI/LO write, no done. In IDLE, flush suppresses that cycle's requests (op_mult/op_div/op_mthi/op_mtlo all dropped). flush has priority over the completion edge.
- hi/lo outputs are direct register reads; they are stable throughout RUN and change only at the completion, mthi/mtlo, or reset edge.
- done and div_zero never assert in the same cycle.

Test Plan:
- Reset, then op_mult a=7, b=0xFFFFFFFD (-3), behavioural core, MULT_CYCLES=32, request in cycle 0 -> mult_start high in cycle 1 only; busy high in cycles 1-33; done high in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- op_div a=100, b=7 -> div_start pulse one cycle; done after DIV_CYCLES+2; lo=14, hi=2.
- op_mthi a=0x12345678, next cycle op_div a=5, b=0 -> hi=0x12345678; div_zero pulse one cycle later; busy stays 0; lo unchanged; no div_start.
- op_mult started, flush asserted at cnt=10 -> IDLE next cycle, busy=0, done never pulses, hi/lo keep prior values.
- op_mult started, reset_n pulled low at cnt=5 between clock edges -> immediately hi=lo=0, busy=0; after release, op_mult 3*4 completes with lo=12, hi=0.
- op_mult and op_div both asserted in the same IDLE cycle, plus op_mult pulsed again while busy -> only one multiply runs; exactly one done pulse; the second request is dropped.
